// File: rtl/div_pkg.sv
// Shared widths, divide-by-zero answer and controller state encoding.
package div_pkg;
    localparam int DVD_W = 10;
    localparam int DVS_W = 3;
    localparam int QUO_W = 20;
    localparam logic [QUO_W-1:0] DZ_QUOT = 20'hFFFFF;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly above ptr, wrapping to the lowest set one.
// Latency: combinational. Backpressure: none, the caller qualifies the grant.
// Grant is one-hot or zero; idx is the encoded winner.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    logic [N_REQ-1:0] upper;

    always_comb begin
        grant = '0;
        idx   = '0;
        upper = '0;
        any   = |req;
        for (int i = 0; i < N_REQ; i++) begin
            upper[i] = req[i] && (i > int'(ptr));
        end
        // Downward scans so the lowest qualifying index wins; the upper-half scan overrides the wrap.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
        if (|upper) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (upper[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    idx      = ID_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// Shares one serial divider between N_REQ requesters, one operation in flight, zero divisors answered locally.
// Latency: accept -> launch 1 cycle; divider out_valid drop -> rsp_valid next cycle.
// Backpressure: requests wait (req_ready low) until the held response is taken by rsp_ready.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*DVD_W-1:0] req_dividend,
    input  logic [N_REQ*DVS_W-1:0] req_divisor,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [QUO_W-1:0]       rsp_quot,
    output logic                   rsp_dz,
    output logic                   dv_in_valid,
    output logic [DVD_W-1:0]       dv_in_data_1,
    output logic [DVS_W-1:0]       dv_in_data_2,
    input  logic                   dv_out_valid,
    input  logic [QUO_W-1:0]       dv_out_data,
    output logic                   busy
);
    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [N_REQ-1:0]   gnt;
    logic               gnt_any;
    logic               accept;
    logic               op_active;
    logic [DVD_W-1:0]   op_dvd, sel_dvd;
    logic [DVS_W-1:0]   op_dvs, sel_dvs;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // A grant during reset would be lost, so acceptance is also gated by rst_n.
    assign accept = (state == IDLE) && gnt_any && rst_n;

    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_dvd = req_dividend[i*DVD_W +: DVD_W];
                sel_dvs = req_divisor[i*DVS_W +: DVS_W];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = accept ? gnt : '0;
        op_active    = (state == LAUNCH) || (state == WAIT) || (state == DRAIN);
        dv_in_valid  = (state == LAUNCH);
        dv_in_data_1 = op_active ? op_dvd : '0;
        dv_in_data_2 = op_active ? op_dvs : '0;
        rsp_valid    = (state == RESP);
        busy         = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = (sel_dvs == '0) ? RESP : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (dv_out_valid) state_nxt = DRAIN;
            DRAIN:   if (!dv_out_valid) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(N_REQ - 1);
            op_dvd   <= '0;
            op_dvs   <= '0;
            rsp_id   <= '0;
            rsp_quot <= '0;
            rsp_dz   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_dvd   <= sel_dvd;
                op_dvs   <= sel_dvs;
                rsp_id   <= gnt_idx;
                rr_ptr   <= gnt_idx;
                rsp_dz   <= (sel_dvs == '0);
                rsp_quot <= (sel_dvs == '0) ? DZ_QUOT : '0;
            end
            // Only the first reporting cycle is captured; DRAIN ignores the rest.
            if (state == WAIT && dv_out_valid) begin
                rsp_quot <= dv_out_data;
            end
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural serial divider and a response scoreboard.
module tb_div_share_ctrl;
    import div_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req_valid;
    logic [N*DVD_W-1:0] req_dividend;
    logic [N*DVS_W-1:0] req_divisor;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [QUO_W-1:0]   rsp_quot;
    logic               rsp_dz;
    logic               dv_in_valid;
    logic [DVD_W-1:0]   dv_in_data_1;
    logic [DVS_W-1:0]   dv_in_data_2;
    logic               dv_out_valid;
    logic [QUO_W-1:0]   dv_out_data;
    logic               busy;
    logic               rsp_en;

    always #5 clk = ~clk;
    assign rsp_ready = rsp_en;

    div_share_ctrl #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quot     (rsp_quot),
        .rsp_dz       (rsp_dz),
        .dv_in_valid  (dv_in_valid),
        .dv_in_data_1 (dv_in_data_1),
        .dv_in_data_2 (dv_in_data_2),
        .dv_out_valid (dv_out_valid),
        .dv_out_data  (dv_out_data),
        .busy         (busy)
    );

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [QUO_W-1:0] quot;
        logic             dz;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int remaining [N];
    logic [DVD_W-1:0] cur_dvd [N];
    logic [DVS_W-1:0] cur_dvs [N];
    exp_t exp_q [$];
    int grant_log [$];
    int accept_cnt = 0, launch_cnt = 0, rsp_cnt = 0;
    int accept_cyc = 0, launch_cyc = 0;
    int overlap_err = 0, hold_err = 0;
    logic [N-1:0] acc;

    int m_cnt = 0, m_ov = 0;
    logic m_busy = 1'b0;
    logic [DVS_W-1:0] m_dvs;

    function automatic logic [QUO_W-1:0] ref_quot(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
        if (b == '0) return DZ_QUOT;
        return QUO_W'((32'(a) * 1024) / 32'(b));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters: grants observed mid-cycle, valids updated just after the accepting edge.
    initial begin
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            cur_dvd[i] = '0;
            cur_dvs[i] = '0;
        end
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            if (rst_n && req_ready != '0) begin
                check("req_ready_onehot", 32'(($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0)), 1);
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) begin
                        exp_t e;
                        e.id   = IDW'(i);
                        e.quot = ref_quot(cur_dvd[i], cur_dvs[i]);
                        e.dz   = (cur_dvs[i] == '0);
                        exp_q.push_back(e);
                        grant_log.push_back(i);
                        remaining[i]--;
                        accept_cnt++;
                        accept_cyc = cyc;
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (remaining[i] > 0);
                req_dividend[i*DVD_W +: DVD_W] = cur_dvd[i];
                req_divisor[i*DVS_W +: DVS_W] = cur_dvs[i];
            end
        end
    end

    // Serial divider model: 20-40 cycle latency, quotient reported for two cycles.
    initial begin
        dv_out_valid = 1'b0;
        dv_out_data = '0;
        m_dvs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_ov = 0;
                dv_out_valid = 1'b0;
                dv_out_data = '0;
            end else if (dv_in_valid) begin
                if (m_busy || m_ov > 0) overlap_err++;
                launch_cnt++;
                launch_cyc = cyc;
                m_busy = 1'b1;
                m_cnt = $urandom_range(20, 40);
                m_dvs = dv_in_data_2;
            end else if (m_busy) begin
                if (dv_in_data_2 !== m_dvs) hold_err++;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    dv_out_data = ref_quot(dv_in_data_1, dv_in_data_2);
                    dv_out_valid = 1'b1;
                    m_ov = 2;
                end
            end else if (m_ov > 0) begin
                if (dv_in_data_2 !== m_dvs) hold_err++;
                m_ov--;
                if (m_ov == 0) begin
                    dv_out_valid = 1'b0;
                    dv_out_data = '0;
                end
            end
        end
    end

    // Response scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_quot", 32'(rsp_quot), 32'(e.quot));
                check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int id, input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b, input int cnt);
        cur_dvd[id] = a;
        cur_dvs[id] = b;
        remaining[id] = cnt;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int budget = 0;
        while (rsp_cnt < target && budget < 3000) begin
            tick();
            budget++;
        end
        check({tag, "_timeout"}, 32'(rsp_cnt >= target), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, 32'({req_ready, rsp_valid, dv_in_valid, busy, rsp_dz}), 0);
        check({tag, "_dvdata"}, 32'({dv_in_data_1, dv_in_data_2}), 0);
        check({tag, "_rsp"}, 32'({rsp_id, rsp_quot}), 0);
    endtask

    int base_a, base_l, base_r, budget, stable_bad;
    logic [IDW+QUO_W+1:0] snap;

    initial begin
        rsp_en = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // 1: single request from 0
        base_a = accept_cnt; base_l = launch_cnt; base_r = rsp_cnt;
        issue(0, 10'd12, 3'd3, 1);
        wait_rsp(base_r + 1, "t1");
        tick(3);
        check("t1_accepts", 32'(accept_cnt - base_a), 1);
        check("t1_launches", 32'(launch_cnt - base_l), 1);
        check("t1_launch_latency", 32'(launch_cyc - accept_cyc), 1);
        check("t1_rsp_count", 32'(rsp_cnt - base_r), 1);

        // 2: fractional quotient, divisor held while the divider iterates
        hold_err = 0;
        base_r = rsp_cnt;
        issue(1, 10'd7, 3'd3, 1);
        wait_rsp(base_r + 1, "t2");
        tick(5);
        check("t2_divisor_held", 32'(hold_err), 0);
        check("t2_rsp_count", 32'(rsp_cnt - base_r), 1);

        // Requester 3 moves the pointer so the rotation below starts at 0
        base_r = rsp_cnt;
        issue(3, 10'd9, 3'd2, 1);
        wait_rsp(base_r + 1, "t3_pre");

        // 3: all requesters contending for eight operations
        grant_log.delete();
        overlap_err = 0;
        base_r = rsp_cnt;
        issue(0, 10'd100, 3'd7, 2);
        issue(1, 10'd200, 3'd5, 2);
        issue(2, 10'd1023, 3'd1, 2);
        issue(3, 10'd50, 3'd6, 2);
        wait_rsp(base_r + 8, "t3");
        check("t3_grant_count", 32'(grant_log.size()), 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) begin
            check("t3_grant_order", 32'(grant_log[i]), 32'(i % N));
        end
        check("t3_overlap", 32'(overlap_err), 0);

        // 4: divide by zero never reaches the divider
        base_l = launch_cnt; base_r = rsp_cnt;
        issue(2, 10'd5, 3'd0, 1);
        wait_rsp(base_r + 1, "t4");
        tick(3);
        check("t4_launches", 32'(launch_cnt - base_l), 0);

        // 5: consumer stalls; fields hold and nothing new is accepted or launched
        rsp_en = 1'b0;
        base_r = rsp_cnt;
        issue(0, 10'd12, 3'd3, 1);
        issue(1, 10'd7, 3'd3, 1);
        budget = 0;
        while (!rsp_valid && budget < 3000) begin
            tick();
            budget++;
        end
        check("t5_rsp_valid_timeout", 32'(rsp_valid), 1);
        snap = {rsp_valid, rsp_id, rsp_quot, rsp_dz};
        base_a = accept_cnt; base_l = launch_cnt;
        stable_bad = 0;
        repeat (10) begin
            tick();
            if ({rsp_valid, rsp_id, rsp_quot, rsp_dz} !== snap) stable_bad++;
        end
        check("t5_rsp_stable", 32'(stable_bad), 0);
        check("t5_no_accept", 32'(accept_cnt - base_a), 0);
        check("t5_no_launch", 32'(launch_cnt - base_l), 0);
        rsp_en = 1'b1;
        wait_rsp(base_r + 2, "t5");

        // 6: reset while the divider is working
        base_l = launch_cnt;
        issue(0, 10'd12, 3'd3, 1);
        budget = 0;
        while (launch_cnt == base_l && budget < 200) begin
            tick();
            budget++;
        end
        check("t6_launch_timeout", 32'(launch_cnt - base_l), 1);
        tick(5);
        rst_n = 1'b0;
        exp_q.delete();
        tick(1);
        check_idle_outputs("t6_reset");
        rst_n = 1'b1;
        tick(2);
        base_r = rsp_cnt;
        issue(0, 10'd12, 3'd3, 1);
        wait_rsp(base_r + 1, "t6");
        tick(60);
        check("t6_rsp_count", 32'(rsp_cnt - base_r), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
